// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Clamp a non-BCD nibble to the largest legal digit.
  function automatic logic [3:0] bcd_sat(input logic [3:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Combinational single-digit BCD decrement with borrow; invalid inputs read as 9.
module bcd_digit_dec
  import timer_pkg::*;
(
  input  logic [3:0] i_digit_in,
  input  logic       i_borrow_in,
  output logic [3:0] o_digit_out,
  output logic       o_borrow_out
);

  logic [3:0] w_sat;

  always_comb begin
    w_sat        = bcd_sat(i_digit_in);
    o_digit_out  = w_sat;
    o_borrow_out = 1'b0;
    if (i_borrow_in) begin
      if (w_sat == 4'd0) begin
        o_digit_out  = BCD_MAX;
        o_borrow_out = 1'b1;
      end else begin
        o_digit_out = w_sat - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable multi-digit BCD down-counter with prescaled decrement, start/pause/load
// controls and a one-cycle expiry pulse.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_load_val,
  input  logic                  i_start,
  input  logic                  i_pause,
  output logic [4*DIGITS-1:0]   o_d,
  output logic                  o_running,
  output logic                  o_zero_tick
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

  state_e          r_state, w_state_nxt;
  logic [W-1:0]    r_d, w_d_nxt;
  logic [PreW-1:0] r_pre, w_pre_nxt;
  logic            r_zero_tick, w_zero_tick_nxt;

  logic [W-1:0]    w_d_dec;
  logic [W-1:0]    w_d_sat;
  logic [DIGITS:0] w_borrow;
  logic            w_d_zero;
  logic            w_dec_zero;
  logic            w_can_dec;
  logic            w_go;

  // Digit 0 always borrows; the chain result is only used on a decrement edge.
  assign w_borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_dec u_dec (
      .i_digit_in  (r_d[4*g +: 4]),
      .i_borrow_in (w_borrow[g]),
      .o_digit_out (w_d_dec[4*g +: 4]),
      .o_borrow_out(w_borrow[g+1])
    );
    assign w_d_sat[4*g +: 4] = bcd_sat(i_load_val[4*g +: 4]);
  end

  // A borrow out of the top digit means the count was already zero.
  assign w_can_dec  = ~w_borrow[DIGITS];
  assign w_d_zero   = (r_d == '0);
  assign w_dec_zero = (w_d_dec == '0);
  assign w_go       = i_start && !i_pause && !w_d_zero;

  always_comb begin
    w_state_nxt     = r_state;
    w_d_nxt         = r_d;
    w_pre_nxt       = r_pre;
    w_zero_tick_nxt = 1'b0;

    if (i_load) begin
      w_d_nxt     = w_d_sat;
      w_pre_nxt   = '0;
      w_state_nxt = StIdle;
    end else begin
      case (r_state)
        StIdle, StPaused: begin
          if (w_go) begin
            w_state_nxt = StRun;
          end
        end
        StRun: begin
          if (i_pause) begin
            w_state_nxt = StPaused;
          end else if (r_pre == PreLast) begin
            w_pre_nxt = '0;
            if (w_can_dec) begin
              w_d_nxt = w_d_dec;
              if (w_dec_zero) begin
                w_zero_tick_nxt = 1'b1;
                w_state_nxt     = StDone;
              end
            end
          end else begin
            w_pre_nxt = r_pre + 1'b1;
          end
        end
        StDone: begin
          w_state_nxt = StDone;
        end
        default: begin
          w_state_nxt = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= StIdle;
      r_d         <= '0;
      r_pre       <= '0;
      r_zero_tick <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_d         <= w_d_nxt;
      r_pre       <= w_pre_nxt;
      r_zero_tick <= w_zero_tick_nxt;
    end
  end

  assign o_d         = r_d;
  assign o_running   = (r_state == StRun);
  assign o_zero_tick = r_zero_tick;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus queues expected outputs per edge,
// a monitor pops and compares them half a cycle later.
module tb_countdown_timer;

  localparam int unsigned DIGITS   = 2;
  localparam int unsigned PRESCALE = 4;

  logic       clk = 1'b0;
  logic       reset, load, start, pause;
  logic [7:0] load_val;
  logic [7:0] d;
  logic       running, zero_tick;

  always #5 clk = ~clk;

  countdown_timer #(
    .DIGITS  (DIGITS),
    .PRESCALE(PRESCALE)
  ) u_dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_load     (load),
    .i_load_val (load_val),
    .i_start    (start),
    .i_pause    (pause),
    .o_d        (d),
    .o_running  (running),
    .o_zero_tick(zero_tick)
  );

  typedef struct {
    logic [7:0] d;
    logic       run;
    logic       zt;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [7:0] bcd2(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  // Drive inputs, wait for the edge, then queue the expected post-edge outputs.
  task automatic step(input logic rst, input logic ld, input logic st, input logic ps,
                      input logic [7:0] lv, input logic [7:0] ed, input logic er,
                      input logic ez, input string nm);
    exp_t e;
    reset    = rst;
    load     = ld;
    start    = st;
    pause    = ps;
    load_val = lv;
    @(posedge clk);
    e.d    = ed;
    e.run  = er;
    e.zt   = ez;
    e.name = nm;
    sb.push_back(e);
    #1;
  endtask

  task automatic idle(input logic [7:0] ed, input logic er, input logic ez, input string nm);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, ed, er, ez, nm);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (d !== e.d || running !== e.run || zero_tick !== e.zt) begin
          n_fail++;
          $display("FAIL %s: got d=%h running=%b zero_tick=%b, want d=%h running=%b zero_tick=%b",
                   e.name, d, running, zero_tick, e.d, e.run, e.zt);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; load_val = 8'h00;

    // 1: reset dominates load and start
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 8'h00, 1'b0, 1'b0, "reset_hold0");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 8'h00, 1'b0, 1'b0, "reset_hold1");

    // 2: full countdown from 12 with expiry
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h12, 8'h12, 1'b0, 1'b0, "load12");
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h12, 1'b1, 1'b0, "start12");
    for (int k = 1; k <= 48; k++) begin
      if (k == 48) idle(8'h00, 1'b0, 1'b1, "expire");
      else         idle(bcd2(12 - k / 4), 1'b1, 1'b0, "count12");
    end
    idle(8'h00, 1'b0, 1'b0, "tick_clear");
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "done_start");
    for (int k = 0; k < 5; k++) idle(8'h00, 1'b0, 1'b0, "done_hold");

    // 3: pause keeps the partial prescale count
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 8'h05, 1'b0, 1'b0, "load05");
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h05, 1'b1, 1'b0, "start05");
    for (int k = 1; k <= 5; k++) idle(bcd2(5 - k / 4), 1'b1, 1'b0, "count05");
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h04, 1'b0, 1'b0, "pause");
    for (int k = 0; k < 10; k++) idle(8'h04, 1'b0, 1'b0, "paused_hold");
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h04, 1'b1, 1'b0, "resume");
    idle(8'h04, 1'b1, 1'b0, "resume_pre2");
    idle(8'h04, 1'b1, 1'b0, "resume_pre3");
    idle(8'h03, 1'b1, 1'b0, "resume_dec");

    // 4: saturation on load, start with zero count
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h3F, 8'h39, 1'b0, 1'b0, "load3F");
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'hA2, 8'h92, 1'b0, 1'b0, "loadA2");
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h99, 1'b0, 1'b0, "loadFF");
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "load00");
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "start_zero");
    idle(8'h00, 1'b0, 1'b0, "zero_idle");
    idle(8'h00, 1'b0, 1'b0, "zero_idle");
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 8'h05, 1'b0, 1'b0, "load05b");
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h05, 1'b0, 1'b0, "idle_start_pause");

    // 5: reset mid-run
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h07, 8'h07, 1'b0, 1'b0, "load07");
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h07, 1'b1, 1'b0, "start07");
    for (int k = 0; k < 2; k++) idle(8'h07, 1'b1, 1'b0, "run07");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "reset_run");
    for (int k = 0; k < 6; k++) idle(8'h00, 1'b0, 1'b0, "post_reset");

    // 6: load beats pause; restart uses a fresh prescaler
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h20, 8'h20, 1'b0, 1'b0, "load20");
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 1'b1, 1'b0, "start20");
    for (int k = 0; k < 2; k++) idle(8'h20, 1'b1, 1'b0, "run20");
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h15, 8'h15, 1'b0, 1'b0, "load_pause");
    idle(8'h15, 1'b0, 1'b0, "after_load");
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h15, 1'b1, 1'b0, "start15");
    for (int k = 0; k < 3; k++) idle(8'h15, 1'b1, 1'b0, "run15");
    idle(8'h14, 1'b1, 1'b0, "dec15");

    reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #6;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries never compared, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable multi-digit BCD down-counter; the counting-down counterpart to the up-counting stopwatch.
- Counts a preset value down to zero at a prescaled tick rate, with start, pause and load controls.
- Emits a one-cycle `zero_tick` on expiry; sits beside the stopwatch and drives the same digit display path.

Parameters:
- DIGITS, 2, number of BCD digits (≥1).
- PRESCALE, 4, clock cycles per decrement (≥1; 1 = decrement every cycle).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low.
- load  in  1  load `load_val` into the counter.
- load_val  in  4*DIGITS  BCD preset; digit 0 is in the least-significant nibble.
- start  in  1  begin or resume counting.
- pause  in  1  suspend counting.
- d  out  4*DIGITS  current BCD count, registered.
- running  out  1  high while the state is RUN.
- zero_tick  out  1  one-cycle pulse when the count reaches 0 by decrementing.

Behaviour:
- Reset (reset==0 at an edge):
  - d=0, state=IDLE, prescaler=0, running=0, zero_tick=0.
  - Reset overrides every other input, including mid-run.
- States: IDLE, RUN, PAUSED, DONE.
  - running = (state==RUN), registered.
- Control priority at each edge: reset > load > pause > start.
- load, in any state:
  - d <= load_val; any nibble >9 saturates to 9.
  - prescaler <= 0; state <= IDLE; zero_tick <= 0.
- start in IDLE or PAUSED:
  - If d != 0, go to RUN.
  - If d == 0, stay in the current state and emit no tick.
  - start is ignored in RUN and DONE.
- pause:
  - In RUN, go to PAUSED; the prescaler value is held.
  - Ignored in other states.
  - pause and start together behave as pause.
- RUN prescaler:
  - Counts 0..PRESCALE-1.
  - At an edge with prescaler==PRESCALE-1: prescaler <= 0 and d decrements by one.
  - Otherwise the prescaler increments and d holds.
  - If start is sampled at edge E0, the first decrement occurs at edge E0+PRESCALE.
- BCD decrement:
  - Digit 0 → 9 with a borrow into the next digit.
  - The borrow ripples across all digits in the same cycle.
  - d is never decremented below 0.
- Expiry:
  - Applies when a decrement produces d==0, i.e. old d == 0…01.
  - At that same edge: zero_tick <= 1 and state <= DONE.
  - zero_tick returns to 0 on the next edge.
- DONE:
  - d holds 0; running=0.
  - Only load or reset leaves DONE.
- PAUSED: d and prescaler hold; start resumes RUN, continuing the partial prescale count.
- Fixed behaviour, no X-propagation: load_val contents are irrelevant unless load is asserted.

Decomposition:
- Package timer_pkg holds:
  - The state encoding: IDLE=2'd0, RUN=2'd1, PAUSED=2'd2, DONE=2'd3.
  - BCD_MAX=4'd9.
- Sub-module bcd_digit_dec:
  - Ports: digit_in[3:0], borrow_in, digit_out[3:0], borrow_out.
  - Combinational single-digit decrement with saturation of invalid input to 9.
  - Instantiated DIGITS times in a generate loop; the top holds the FSM, prescaler and registers.

Test Plan (DIGITS=2, PRESCALE=4):
1. Hold reset=0 for 2 edges with start=1 and load=1 → d=8'h00, running=0, zero_tick=0 throughout.
2. Load 8'h12, then start at edge E0:
   - d steps 12→11→10→09 at E0+4, +8, +12; the 10→09 borrow is correct.
   - At E0+48, d=00, zero_tick=1 for exactly one cycle, running=0, state DONE.
   - A later start leaves d=00.
3. Load 8'h05, start at E0, pause at E0+6 (d=04, prescaler=1), hold for 10 cycles (d stays 04), start at E1:
   - Next decrement to 03 at E1+3.
4. Load 8'h3F → d=8'h39. Then load 8'h00 and start → state stays IDLE, running=0, no zero_tick.
5. Running with d=8'h07, drive reset=0 for one edge → d=00, running=0 at that edge. With reset=1 and no start, d stays 00.
6. Running at d=8'h20, assert load with 8'h15 together with pause → d=15, state IDLE, running=0. Start then resumes counting from 15 with a fresh prescaler.
